// File: rtl/mypackage.sv
// rtl/mypackage.sv - shared writeback FSM state type and result width
package mypackage;

  typedef enum logic [1:0] {WB_IDLE, WB_LO, WB_HI} wb_state_t;

  localparam int WB_RESULT_W = 64;

endpackage

// File: rtl/frv_wb_slot.sv
// rtl/frv_wb_slot.sv - holding register for the pending writeback (rd, wide flag, 64-bit result)
// Wide destinations are stored already aligned to the even pair base.
module frv_wb_slot
  import mypackage::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   load,
  input  logic [ADDR_W-1:0]      rd,
  input  logic                   wide,
  input  logic [WB_RESULT_W-1:0] result,
  output logic [ADDR_W-1:0]      rd_q,
  output logic                   wide_q,
  output logic [WB_RESULT_W-1:0] res_q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_q   <= '0;
      wide_q <= 1'b0;
      res_q  <= '0;
    end else if (load) begin
      rd_q   <= wide ? {rd[ADDR_W-1:1], 1'b0} : rd;
      wide_q <= wide;
      res_q  <= result;
    end
  end

endmodule

// File: rtl/frv_wide_writeback.sv
// rtl/frv_wide_writeback.sv - serialises 64-bit execute results onto the 32-bit GPR write port
// Optional high-word forwarding is enabled by defining FRV_WB_FWD_EN.
module frv_wide_writeback
  import mypackage::*;
#(
  parameter int ADDR_W     = 5,
  parameter int ZERO_GUARD = 1
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_wide,
  input  logic [ADDR_W-1:0]      s_rd,
  input  logic [WB_RESULT_W-1:0] s_result,
  output logic                   rf_wen,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic                   busy,
  output logic [ADDR_W-1:0]      busy_rd,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_addr,
  output logic [31:0]            fwd_data
);

  wb_state_t                state, state_next;
  logic [ADDR_W-1:0]        rd_q;
  logic                     wide_q;
  logic [WB_RESULT_W-1:0]   res_q;
  logic                     stop;
  logic                     accept;

  assign stop   = g_reset | flush;
  assign accept = s_valid & s_ready;

  frv_wb_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk    (g_clk),
    .clear  (stop),
    .load   (accept),
    .rd     (s_rd),
    .wide   (s_wide),
    .result (s_result),
    .rd_q   (rd_q),
    .wide_q (wide_q),
    .res_q  (res_q)
  );

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= WB_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = WB_IDLE;
    end else begin
      case (state)
        WB_IDLE: state_next = accept ? WB_LO : WB_IDLE;
        WB_LO:   state_next = wide_q ? WB_HI : (accept ? WB_LO : WB_IDLE);
        WB_HI:   state_next = accept ? WB_LO : WB_IDLE;
        default: state_next = WB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      WB_IDLE: s_ready = !stop;
      WB_LO: begin
        s_ready  = !stop && !wide_q;
        rf_wen   = !stop;
        rf_waddr = rd_q;
        rf_wdata = res_q[31:0];
      end
      WB_HI: begin
        s_ready  = !stop;
        rf_wen   = !stop;
        rf_waddr = {rd_q[ADDR_W-1:1], 1'b1};
        rf_wdata = res_q[63:32];
      end
      default: s_ready = 1'b0;
    endcase
    // x0 is hardwired; the slot still takes its cycle so pair timing is unchanged
    if (ZERO_GUARD != 0 && rf_waddr == '0) rf_wen = 1'b0;
    if (!rf_wen) begin
      rf_waddr = '0;
      rf_wdata = '0;
    end
  end

  assign busy    = !g_reset && (state != WB_IDLE);
  assign busy_rd = busy ? rd_q : '0;

`ifdef FRV_WB_FWD_EN
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (state == WB_LO && wide_q && !stop) begin
      fwd_valid = 1'b1;
      fwd_addr  = {rd_q[ADDR_W-1:1], 1'b1};
      fwd_data  = res_q[63:32];
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_frv_wide_writeback.sv
// tb/tb_frv_wide_writeback.sv - directed scoreboard bench for frv_wide_writeback
module tb_frv_wide_writeback;

  localparam int ADDR_W = 5;
`ifdef FRV_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              g_clk = 1'b0;
  logic              g_reset, flush, s_valid, s_wide;
  logic              s_ready, rf_wen, busy, fwd_valid;
  logic [ADDR_W-1:0] s_rd, rf_waddr, busy_rd, fwd_addr;
  logic [63:0]       s_result;
  logic [31:0]       rf_wdata, fwd_data;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 g_clk = ~g_clk;

  frv_wide_writeback #(.ADDR_W(ADDR_W), .ZERO_GUARD(1)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_wide    (s_wide),
    .s_rd      (s_rd),
    .s_result  (s_result),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .busy_rd   (busy_rd),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge g_clk);
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] rd,
                       input logic [63:0] res);
    s_valid  = v;
    s_wide   = w;
    s_rd     = rd;
    s_result = res;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every register-file write must match the oldest expected write
  always @(negedge g_clk) begin
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {63'd0, rf_wen}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_addr", {59'd0, rf_waddr}, {59'd0, e.addr});
        check("wb_data", {32'd0, rf_wdata}, {32'd0, e.data});
      end
    end
  end

  initial begin
    g_reset = 1'b1;
    flush   = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    at_neg();
    check("reset_ready", {63'd0, s_ready}, 64'd0);
    check("reset_wen", {63'd0, rf_wen}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_fwd", {63'd0, fwd_valid}, 64'd0);
    tick();
    g_reset = 1'b0;
    at_neg();
    check("idle_ready", {63'd0, s_ready}, 64'd1);

    // Narrow write
    tick();
    push(5'd5, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 5'd5, 64'h0000_0000_DEAD_BEEF);
    at_neg();
    check("t1_accept_ready", {63'd0, s_ready}, 64'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("t1_lo_busy", {63'd0, busy}, 64'd1);
    check("t1_busy_rd", {59'd0, busy_rd}, 64'd5);
    check("t1_lo_wen", {63'd0, rf_wen}, 64'd1);
    tick();
    at_neg();
    check("t1_idle_busy", {63'd0, busy}, 64'd0);
    check("t1_idle_wen", {63'd0, rf_wen}, 64'd0);

    // Wide pair write
    tick();
    push(5'd6, 32'h33334444);
    push(5'd7, 32'h11112222);
    drive(1'b1, 1'b1, 5'd6, 64'h1111_2222_3333_4444);
    at_neg();
    check("t2_accept_ready", {63'd0, s_ready}, 64'd1);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("t2_lo_ready", {63'd0, s_ready}, 64'd0);
    check("t2_busy_rd", {59'd0, busy_rd}, 64'd6);
    tick();
    at_neg();
    check("t2_hi_ready", {63'd0, s_ready}, 64'd1);
    tick();
    at_neg();
    check("t2_idle_busy", {63'd0, busy}, 64'd0);

    // Four back-to-back narrow ops
    for (int i = 1; i <= 4; i++) begin
      tick();
      push(ADDR_W'(i), 32'hA5A5_0000 + 32'(i));
      drive(1'b1, 1'b0, ADDR_W'(i), {32'hFFFF_FFFF, 32'hA5A5_0000 + 32'(i)});
      at_neg();
      check("t3_ready", {63'd0, s_ready}, 64'd1);
      if (i > 1) check("t3_no_bubble", {63'd0, rf_wen}, 64'd1);
    end
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("t3_last_wen", {63'd0, rf_wen}, 64'd1);
    tick();
    at_neg();
    check("t3_idle_wen", {63'd0, rf_wen}, 64'd0);

    // Wide to x0: low half suppressed, x1 written
    tick();
    push(5'd1, 32'h5555AAAA);
    drive(1'b1, 1'b1, 5'd0, 64'h5555_AAAA_1234_5678);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("t4_lo_wen", {63'd0, rf_wen}, 64'd0);
    check("t4_lo_waddr", {59'd0, rf_waddr}, 64'd0);
    check("t4_lo_wdata", {32'd0, rf_wdata}, 64'd0);
    check("t4_lo_busy", {63'd0, busy}, 64'd1);
    tick();
    at_neg();

    // Wide with odd rd uses the pair base
    tick();
    push(5'd12, 32'h0C0C_0C0C);
    push(5'd13, 32'h0D0D_0D0D);
    drive(1'b1, 1'b1, 5'd13, 64'h0D0D_0D0D_0C0C_0C0C);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("odd_busy_rd", {59'd0, busy_rd}, 64'd12);
    tick();
    tick();

    // Flush in the LO cycle of a wide op
    drive(1'b1, 1'b1, 5'd8, 64'h8888_8888_9999_9999);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    flush = 1'b1;
    at_neg();
    check("t5_flush_wen", {63'd0, rf_wen}, 64'd0);
    check("t5_flush_ready", {63'd0, s_ready}, 64'd0);
    check("t5_flush_fwd", {63'd0, fwd_valid}, 64'd0);
    tick();
    flush = 1'b0;
    at_neg();
    check("t5_after_busy", {63'd0, busy}, 64'd0);
    check("t5_after_wen", {63'd0, rf_wen}, 64'd0);
    tick();
    at_neg();
    check("t5_later_wen", {63'd0, rf_wen}, 64'd0);

    // High-word forwarding
    tick();
    push(5'd10, 32'h0BADC0DE);
    push(5'd11, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 5'd10, 64'hCAFE_F00D_0BAD_C0DE);
    at_neg();
    check("t6_idle_fwd", {63'd0, fwd_valid}, 64'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    at_neg();
    check("t6_lo_fwd_valid", {63'd0, fwd_valid}, {63'd0, FWD});
    check("t6_lo_fwd_addr", {59'd0, fwd_addr}, FWD ? 64'd11 : 64'd0);
    check("t6_lo_fwd_data", {32'd0, fwd_data}, FWD ? 64'hCAFEF00D : 64'd0);
    tick();
    at_neg();
    check("t6_hi_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("t6_hi_fwd_data", {32'd0, fwd_data}, 64'd0);

    // Reset in the middle of a wide op
    tick();
    drive(1'b1, 1'b1, 5'd20, 64'h2121_2121_2020_2020);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    g_reset = 1'b1;
    at_neg();
    check("rst_wen", {63'd0, rf_wen}, 64'd0);
    check("rst_ready", {63'd0, s_ready}, 64'd0);
    tick();
    g_reset = 1'b0;
    at_neg();
    check("rst_after_busy", {63'd0, busy}, 64'd0);
    check("rst_after_busy_rd", {59'd0, busy_rd}, 64'd0);
    check("rst_after_wen", {63'd0, rf_wen}, 64'd0);

    tick();
    at_neg();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
